// File: rtl/zl_prbs_pkg.sv
// Shared types and helpers for the PRBS checker: sync-state encoding, serial LFSR step, popcount.
package zl_prbs_pkg;

  localparam int unsigned MaxW = 64;
  localparam int unsigned MaxP = 64;

  typedef logic [MaxW-1:0] lfsr_t;
  typedef logic [MaxP-1:0] beat_t;
  typedef logic [7:0]      pcnt_t;

  typedef enum logic [1:0] {
    SyncHunt   = 2'd0,
    SyncVerify = 2'd1,
    SyncLocked = 2'd2
  } sync_e;

  // One serial step of a w-bit LFSR: shift left, feedback parity of tapped bits into the LSb.
  function automatic lfsr_t lfsr_step(lfsr_t s, lfsr_t taps, int unsigned w);
    lfsr_t mask;
    mask = (w >= MaxW) ? '1 : ((lfsr_t'(1) << w) - lfsr_t'(1));
    return ((s << 1) | lfsr_t'(^(s & taps))) & mask;
  endfunction

  function automatic pcnt_t popcount(beat_t v);
    pcnt_t n;
    n = '0;
    for (int i = 0; i < int'(MaxP); i++) begin
      n = n + pcnt_t'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/zl_prbs_if.sv
// Beat input and status output bundle of the PRBS checker.
interface zl_prbs_if #(
  parameter int unsigned PRBS_width = 8,
  parameter int unsigned CNT_width  = 32
);
  logic                  clear;
  logic                  in_valid;
  logic [PRBS_width-1:0] in_data;
  logic                  locked;
  logic [1:0]            sync_state;
  logic [CNT_width-1:0]  err_cnt;
  logic [CNT_width-1:0]  bit_cnt;
  logic                  beat_err;

  modport master (
    output clear, in_valid, in_data,
    input  locked, sync_state, err_cnt, bit_cnt, beat_err
  );

  modport slave (
    input  clear, in_valid, in_data,
    output locked, sync_state, err_cnt, bit_cnt, beat_err
  );
endinterface

// File: rtl/zl_prbs_predict.sv
// Combinational P-step LFSR expansion: state after P steps and the P predicted bits (MSb first).
module zl_prbs_predict import zl_prbs_pkg::*; #(
  parameter logic [MaxW:0] LFSR_poly  = 65'hC001,
  parameter int unsigned   LFSR_width = 15,
  parameter int unsigned   PRBS_width = 8
) (
  input  logic [LFSR_width-1:0] state_i,
  output logic [LFSR_width-1:0] next_state_o,
  output logic [PRBS_width-1:0] pred_o
);

  lfsr_t taps;
  lfsr_t s;

  assign taps = lfsr_t'(LFSR_poly[LFSR_width:1]);

  always_comb begin
    s      = lfsr_t'(state_i);
    pred_o = '0;
    for (int i = 0; i < int'(PRBS_width); i++) begin
      s = lfsr_step(s, taps, LFSR_width);
      pred_o[PRBS_width-1-i] = s[0];
    end
    next_state_o = s[LFSR_width-1:0];
  end

endmodule

// File: rtl/zl_prbs_checker.sv
// Self-synchronising PRBS checker: hunts/verifies lock on the incoming stream, then free-runs
// and accumulates saturating bit-error and bit counts for BER measurement.
module zl_prbs_checker import zl_prbs_pkg::*; #(
  parameter logic [MaxW:0] LFSR_poly    = 65'hC001,
  parameter int unsigned   LFSR_width   = 15,
  parameter int unsigned   PRBS_width   = 8,
  parameter int unsigned   LOCK_BEATS   = 4,
  parameter int unsigned   UNLOCK_BEATS = 4,
  parameter int unsigned   ERR_THRESH   = 0,
  parameter int unsigned   CNT_width    = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  zl_prbs_if.slave  prbs_io
);

  localparam int unsigned FillBeats = (LFSR_width + PRBS_width - 1) / PRBS_width;
  localparam int unsigned FillW     = $clog2(FillBeats + 1);
  localparam int unsigned GoodW     = $clog2(LOCK_BEATS + 1);
  localparam int unsigned BadW      = $clog2(UNLOCK_BEATS + 1);
  localparam int unsigned SumW      = ((CNT_width > 8) ? CNT_width : 8) + 1;

  typedef logic [SumW-1:0] sum_t;
  localparam sum_t CntMax = sum_t'({CNT_width{1'b1}});

  sync_e                 state_q;
  logic [LFSR_width-1:0] lfsr_q, lfsr_load, lfsr_run;
  logic [PRBS_width-1:0] pred;
  logic [FillW-1:0]      fill_q;
  logic [GoodW-1:0]      good_q;
  logic [BadW-1:0]       bad_q;
  logic                  locked_q, beat_err_q;
  logic [CNT_width-1:0]  err_cnt_q, err_cnt_d, bit_cnt_q, bit_cnt_d;
  pcnt_t                 n_err;
  sum_t                  err_sum, bit_sum;
  logic                  bad_beat;

  zl_prbs_predict #(
    .LFSR_poly (LFSR_poly),
    .LFSR_width(LFSR_width),
    .PRBS_width(PRBS_width)
  ) u_predict (
    .state_i     (lfsr_q),
    .next_state_o(lfsr_run),
    .pred_o      (pred)
  );

  // Self-sync load: received bits enter the LSb oldest-first, keeping the prediction aligned.
  always_comb begin
    lfsr_load = lfsr_q;
    for (int i = 0; i < int'(PRBS_width); i++) begin
      lfsr_load = {lfsr_load[LFSR_width-2:0], prbs_io.in_data[PRBS_width-1-i]};
    end
  end

  always_comb begin
    n_err     = popcount(beat_t'(pred ^ prbs_io.in_data));
    bad_beat  = (32'(n_err) > ERR_THRESH);
    err_sum   = sum_t'(err_cnt_q) + sum_t'(n_err);
    bit_sum   = sum_t'(bit_cnt_q) + sum_t'(PRBS_width);
    err_cnt_d = (err_sum > CntMax) ? '1 : err_sum[CNT_width-1:0];
    bit_cnt_d = (bit_sum > CntMax) ? '1 : bit_sum[CNT_width-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SyncHunt;
      lfsr_q     <= '0;
      fill_q     <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      locked_q   <= 1'b0;
      beat_err_q <= 1'b0;
      err_cnt_q  <= '0;
      bit_cnt_q  <= '0;
    end else if (prbs_io.clear) begin
      state_q    <= SyncHunt;
      lfsr_q     <= '0;
      fill_q     <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      locked_q   <= 1'b0;
      beat_err_q <= 1'b0;
      err_cnt_q  <= '0;
      bit_cnt_q  <= '0;
    end else begin
      beat_err_q <= 1'b0;
      if (prbs_io.in_valid) begin
        unique case (state_q)
          SyncHunt: begin
            lfsr_q <= lfsr_load;
            fill_q <= fill_q + 1'b1;
            if (32'(fill_q) + 1 == FillBeats) begin
              state_q <= SyncVerify;
              good_q  <= '0;
            end
          end
          SyncVerify: begin
            lfsr_q <= lfsr_load;
            if (n_err == '0) begin
              good_q <= good_q + 1'b1;
              if (32'(good_q) + 1 == LOCK_BEATS) begin
                state_q  <= SyncLocked;
                locked_q <= 1'b1;
                bad_q    <= '0;
              end
            end else begin
              good_q <= '0;
            end
          end
          SyncLocked: begin
            // Free-run on the prediction so a received error never corrupts the reference.
            lfsr_q     <= lfsr_run;
            err_cnt_q  <= err_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            beat_err_q <= (n_err != '0);
            if (bad_beat) begin
              bad_q <= bad_q + 1'b1;
              if (32'(bad_q) + 1 == UNLOCK_BEATS) begin
                state_q  <= SyncHunt;
                locked_q <= 1'b0;
                fill_q   <= '0;
              end
            end else begin
              bad_q <= '0;
            end
          end
          default: state_q <= SyncHunt;
        endcase
      end
    end
  end

  assign prbs_io.locked     = locked_q;
  assign prbs_io.sync_state = state_q;
  assign prbs_io.err_cnt    = err_cnt_q;
  assign prbs_io.bit_cnt    = bit_cnt_q;
  assign prbs_io.beat_err   = beat_err_q;

endmodule

// File: tb/tb_zl_prbs_checker.sv
// Scoreboard bench: two checkers (32-bit counters / ERR_THRESH 0, and 4-bit counters /
// ERR_THRESH 8) share one stimulus stream and are checked against a bit-history reference model.
module tb_zl_prbs_checker;

  localparam int unsigned W       = 15;
  localparam int unsigned P       = 8;
  localparam int unsigned FillN   = (W + P - 1) / P;
  localparam int unsigned LockN   = 4;
  localparam int unsigned UnlockN = 4;

  typedef struct packed {
    bit        lk;
    bit [1:0]  st;
    bit [31:0] err;
    bit [31:0] bc;
    bit        be;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  zl_prbs_if #(.PRBS_width(P), .CNT_width(32)) bus0 ();
  zl_prbs_if #(.PRBS_width(P), .CNT_width(4))  bus1 ();

  zl_prbs_checker #(
    .LFSR_poly(65'hC001), .LFSR_width(W), .PRBS_width(P), .LOCK_BEATS(LockN),
    .UNLOCK_BEATS(UnlockN), .ERR_THRESH(0), .CNT_width(32)
  ) dut0 (.clk(clk), .rst_n(rst_n), .prbs_io(bus0));

  zl_prbs_checker #(
    .LFSR_poly(65'hC001), .LFSR_width(W), .PRBS_width(P), .LOCK_BEATS(LockN),
    .UNLOCK_BEATS(UnlockN), .ERR_THRESH(8), .CNT_width(4)
  ) dut1 (.clk(clk), .rst_n(rst_n), .prbs_io(bus1));

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [64:0] poly_v   = 65'hC001;
  logic [14:0] gen_init = 15'h00A9;

  // Bit histories: index W-1 is the newest bit, index W-j is the bit j steps back.
  bit [W-1:0] gen_h;
  bit [W-1:0] hist [2];
  int         m_st [2];
  int         m_fill [2];
  int         m_good [2];
  int         m_bad [2];
  longint     m_err [2];
  longint     m_bit [2];
  bit         m_be [2];
  int         thr [2]  = '{0, 8};
  longint     cmax [2] = '{64'hFFFF_FFFF, 64'hF};
  exp_t       q0[$];
  exp_t       q1[$];
  exp_t       x0, x1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // PRBS recurrence: b[n] = XOR of b[n-j] over every tap j in poly[W:1].
  function automatic bit rec_bit(input bit [W-1:0] h);
    bit r;
    r = 1'b0;
    for (int j = 1; j <= int'(W); j++) begin
      if (poly_v[j]) r ^= h[W-j];
    end
    return r;
  endfunction

  task automatic gen_reset();
    for (int k = 0; k < int'(W); k++) gen_h[W-1-k] = gen_init[k];
  endtask

  task automatic gen_beat(output logic [P-1:0] d);
    bit nb;
    for (int i = 0; i < int'(P); i++) begin
      nb    = rec_bit(gen_h);
      gen_h = {nb, gen_h[W-1:1]};
      d[P-1-i] = nb;
    end
  endtask

  task automatic model_reset(input int k);
    m_st[k]   = 0;
    m_fill[k] = 0;
    m_good[k] = 0;
    m_bad[k]  = 0;
    m_err[k]  = 0;
    m_bit[k]  = 0;
    m_be[k]   = 1'b0;
    hist[k]   = '0;
  endtask

  task automatic model_cycle(input int k, input bit clr, input bit v, input logic [P-1:0] d);
    bit [W-1:0] ph;
    logic [P-1:0] p;
    int e;
    bit nb;
    exp_t x;
    m_be[k] = 1'b0;
    if (clr) begin
      model_reset(k);
    end else if (v) begin
      ph = hist[k];
      for (int i = 0; i < int'(P); i++) begin
        nb = rec_bit(ph);
        ph = {nb, ph[W-1:1]};
        p[P-1-i] = nb;
      end
      e = $countones(p ^ d);
      if (m_st[k] == 2) begin
        hist[k]  = ph;
        m_err[k] = (m_err[k] + e > cmax[k]) ? cmax[k] : m_err[k] + e;
        m_bit[k] = (m_bit[k] + P > cmax[k]) ? cmax[k] : m_bit[k] + P;
        m_be[k]  = (e > 0);
        if (e > thr[k]) begin
          m_bad[k]++;
          if (m_bad[k] == UnlockN) begin
            m_st[k]   = 0;
            m_fill[k] = 0;
          end
        end else begin
          m_bad[k] = 0;
        end
      end else begin
        for (int i = 0; i < int'(P); i++) hist[k] = {d[P-1-i], hist[k][W-1:1]};
        if (m_st[k] == 0) begin
          m_fill[k]++;
          if (m_fill[k] == FillN) begin
            m_st[k]   = 1;
            m_good[k] = 0;
          end
        end else if (e == 0) begin
          m_good[k]++;
          if (m_good[k] == LockN) begin
            m_st[k]  = 2;
            m_bad[k] = 0;
          end
        end else begin
          m_good[k] = 0;
        end
      end
    end
    x.lk  = (m_st[k] == 2);
    x.st  = 2'(m_st[k]);
    x.err = 32'(m_err[k]);
    x.bc  = 32'(m_bit[k]);
    x.be  = m_be[k];
    if (k == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  // One clock of stimulus; the expected post-edge outputs go straight to the scoreboard.
  task automatic cyc(input bit clr, input bit v, input logic [P-1:0] d);
    @(negedge clk);
    bus0.clear = clr; bus0.in_valid = v; bus0.in_data = d;
    bus1.clear = clr; bus1.in_valid = v; bus1.in_data = d;
    model_cycle(0, clr, v, d);
    model_cycle(1, clr, v, d);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #3;
  endtask

  always @(posedge clk) begin
    #2;
    if (q0.size() != 0) begin
      x0 = q0.pop_front();
      check("d0_locked",   64'(bus0.locked),     64'(x0.lk));
      check("d0_state",    64'(bus0.sync_state), 64'(x0.st));
      check("d0_err_cnt",  64'(bus0.err_cnt),    64'(x0.err));
      check("d0_bit_cnt",  64'(bus0.bit_cnt),    64'(x0.bc));
      check("d0_beat_err", 64'(bus0.beat_err),   64'(x0.be));
    end
    if (q1.size() != 0) begin
      x1 = q1.pop_front();
      check("d1_locked",   64'(bus1.locked),     64'(x1.lk));
      check("d1_state",    64'(bus1.sync_state), 64'(x1.st));
      check("d1_err_cnt",  64'(bus1.err_cnt),    64'(x1.err));
      check("d1_bit_cnt",  64'(bus1.bit_cnt),    64'(x1.bc));
      check("d1_beat_err", 64'(bus1.beat_err),   64'(x1.be));
    end
  end

  initial begin
    logic [P-1:0] d;
    int vb;
    int idx;
    bit v;
    bus0.clear = 1'b0; bus0.in_valid = 1'b0; bus0.in_data = '0;
    bus1.clear = 1'b0; bus1.in_valid = 1'b0; bus1.in_data = '0;
    model_reset(0);
    model_reset(1);
    repeat (3) @(posedge clk);
    #3;
    check("rst_locked", 64'(bus0.locked), 64'd0);
    check("rst_state",  64'(bus0.sync_state), 64'd0);
    check("rst_err",    64'(bus0.err_cnt), 64'd0);
    check("rst_bit",    64'(bus0.bit_cnt), 64'd0);
    check("rst_beat",   64'(bus0.beat_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean stream: 2 HUNT beats, 4 VERIFY beats, locked on the 6th.
    gen_reset();
    for (int b = 1; b <= 200; b++) begin
      gen_beat(d);
      cyc(1'b0, 1'b1, d);
      if (b == 1) begin after_edge(); check("s1_hunt_b1",   64'(bus0.sync_state), 64'd0); end
      if (b == 2) begin after_edge(); check("s1_verify_b2", 64'(bus0.sync_state), 64'd1); end
      if (b == 5) begin after_edge(); check("s1_unlock_b5", 64'(bus0.locked), 64'd0); end
      if (b == 6) begin after_edge(); check("s1_lock_b6",   64'(bus0.locked), 64'd1); end
    end
    after_edge();
    check("s1_bit_cnt", 64'(bus0.bit_cnt), 64'd1552);
    check("s1_err_cnt", 64'(bus0.err_cnt), 64'd0);

    // Single flipped bit while locked.
    gen_beat(d);
    d[3] = ~d[3];
    cyc(1'b0, 1'b1, d);
    after_edge();
    check("s2_beat_err", 64'(bus0.beat_err), 64'd1);
    check("s2_err_cnt",  64'(bus0.err_cnt), 64'd1);
    check("s2_locked",   64'(bus0.locked), 64'd1);
    for (int b = 0; b < 9; b++) begin
      gen_beat(d);
      cyc(1'b0, 1'b1, d);
    end
    after_edge();
    check("s2_no_prop", 64'(bus0.err_cnt), 64'd1);

    // Four fully-wrong beats drop lock on dut0; clean stream relocks in 6 beats.
    for (int b = 1; b <= 4; b++) begin
      gen_beat(d);
      cyc(1'b0, 1'b1, ~d);
      if (b == 3) begin after_edge(); check("s3_still_lock", 64'(bus0.locked), 64'd1); end
    end
    after_edge();
    check("s3_unlock", 64'(bus0.locked), 64'd0);
    check("s3_state",  64'(bus0.sync_state), 64'd0);
    check("s3_err",    64'(bus0.err_cnt), 64'd33);
    check("s3_bit",    64'(bus0.bit_cnt), 64'd1664);
    for (int b = 1; b <= 6; b++) begin
      gen_beat(d);
      cyc(1'b0, 1'b1, d);
      if (b == 5) begin after_edge(); check("s3_relock_b5", 64'(bus0.locked), 64'd0); end
    end
    after_edge();
    check("s3_relock_b6", 64'(bus0.locked), 64'd1);
    check("s3_bit_hold",  64'(bus0.bit_cnt), 64'd1664);

    // Clear together with a valid beat.
    gen_beat(d);
    cyc(1'b1, 1'b1, d);
    after_edge();
    check("s5_state", 64'(bus0.sync_state), 64'd0);
    check("s5_err",   64'(bus0.err_cnt), 64'd0);
    check("s5_bit",   64'(bus0.bit_cnt), 64'd0);
    cyc(1'b0, 1'b0, '0);

    // Gapped valid, same stream as the clean run.
    gen_reset();
    vb = 0;
    while (vb < 200) begin
      gen_beat(d);
      cyc(1'b0, 1'b1, d);
      vb++;
      if (vb == 5) begin after_edge(); check("s4_unlock_b5", 64'(bus0.locked), 64'd0); end
      if (vb == 6) begin after_edge(); check("s4_lock_b6",   64'(bus0.locked), 64'd1); end
      cyc(1'b0, 1'b0, P'($urandom));
    end
    after_edge();
    check("s4_bit_cnt", 64'(bus0.bit_cnt), 64'd1552);
    check("s4_err_cnt", 64'(bus0.err_cnt), 64'd0);

    // Sustained errors: dut1 (4-bit counters, threshold 8) saturates and stays locked.
    for (int b = 0; b < 20; b++) begin
      gen_beat(d);
      cyc(1'b0, 1'b1, ~d);
    end
    after_edge();
    check("s6_sat_err",  64'(bus1.err_cnt), 64'hF);
    check("s6_sat_bit",  64'(bus1.bit_cnt), 64'hF);
    check("s6_sat_lock", 64'(bus1.locked), 64'd1);

    // Randomized gaps, bit flips and occasional clears.
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 3) != 0);
      if (v) begin
        gen_beat(d);
        if ($urandom_range(0, 7) == 0) begin
          idx = $urandom_range(0, P - 1);
          d[idx] = ~d[idx];
        end
      end else begin
        d = P'($urandom);
      end
      cyc(($urandom_range(0, 149) == 0), v, d);
    end
    for (int b = 0; b < 12; b++) begin
      gen_beat(d);
      cyc(1'b0, 1'b1, d);
    end

    // Asynchronous reset between clock edges clears every output at once.
    after_edge();
    rst_n = 1'b0;
    #1;
    check("ar_locked", 64'(bus0.locked), 64'd0);
    check("ar_state",  64'(bus0.sync_state), 64'd0);
    check("ar_err",    64'(bus0.err_cnt), 64'd0);
    check("ar_bit",    64'(bus0.bit_cnt), 64'd0);
    check("ar_beat",   64'(bus0.beat_err), 64'd0);
    check("ar_d1_err", 64'(bus1.err_cnt), 64'd0);
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int b = 0; b < 10; b++) begin
      gen_beat(d);
      cyc(1'b0, 1'b1, d);
    end
    cyc(1'b0, 1'b0, '0);
    after_edge();
    check("ar_relock", 64'(bus0.locked), 64'd1);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/zl_prbs_checker.md
Name: zl_prbs_checker

Overview:
Receive-side counterpart of the team's parallel LFSR/PRBS generator. It takes a PRBS_width-bit PRBS vector per valid beat, with the oldest bit in the MSb. It self-synchronises an LFSR to the incoming stream, declares lock, then free-runs and counts bit errors for BER measurement. It sits after the demapper/deframer on loopback and test paths, and in the energy-dispersal verification chain.

Parameters:
LFSR_poly, 0, feedback polynomial; only bits [LFSR_width:1] are used; tap set = state & LFSR_poly[LFSR_width:1]
LFSR_width, 0, LFSR state width (>=2)
PRBS_width, 0, bits per input beat (>=1; any relation to LFSR_width)
LOCK_BEATS, 4, consecutive error-free beats in VERIFY needed to lock
UNLOCK_BEATS, 4, consecutive bad beats in LOCKED needed to drop lock
ERR_THRESH, 0, a beat is bad when its bit-error count > ERR_THRESH
CNT_width, 32, width of the err_cnt and bit_cnt counters

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
clear  in  1  sync clear: state -> HUNT, counters -> 0 (independent of in_valid)
in_valid  in  1  in_data valid this cycle
in_data  in  PRBS_width  received PRBS bits, MSb = first in time
locked  out  1  registered; 1 in LOCKED
sync_state  out  2  0=HUNT, 1=VERIFY, 2=LOCKED
err_cnt  out  CNT_width  bit errors accumulated while LOCKED; saturating
bit_cnt  out  CNT_width  bits checked while LOCKED; saturating
beat_err  out  1  registered 1-cycle pulse: LOCKED beat with >=1 bit error

Behaviour:
- Reset: HUNT, lfsr state 0, fill/good/bad counters 0, locked=0, sync_state=0, err_cnt=0, bit_cnt=0, beat_err=0.
- Serial step (same as the generator): s' = {s[W-2:0], ^(s & LFSR_poly[W:1])}. Per beat, predicted bit p[P-1-i] = LSb after step i+1, for i=0..P-1.
- Nothing advances when in_valid=0, except clear.
- Self-sync load L(s,d): shift the bits of d into s one at a time, MSb first, each into the LSb position.
- HUNT: on each valid beat, s <= L(s,in_data) and fill++. When fill reaches ceil(W/P), go to VERIFY and set good=0.
- VERIFY: on each valid beat:
  - e = popcount(p ^ in_data); s <= L(s,in_data), which keeps resyncing.
  - e==0: good++; when good reaches LOCK_BEATS, go to LOCKED, bad=0.
  - e!=0: good=0 and stay in VERIFY.
- LOCKED: on each valid beat:
  - s <= predicted state after P steps (free-run; errors do not propagate).
  - err_cnt += e; bit_cnt += P; both saturate at all-ones.
  - beat_err=1 the next cycle if e>0.
  - e>ERR_THRESH: bad++; when bad reaches UNLOCK_BEATS, go to HUNT with fill=0.
  - e<=ERR_THRESH: bad=0.
- Latency: outputs are registered, updated on the clock edge that consumes the beat. locked rises on the edge consuming the LOCK_BEATS-th good beat.
- Counters are not cleared on loss of lock, only by clear or reset. The first beat after re-entering LOCKED counts normally.
- clear with in_valid in the same cycle: clear wins and the beat is discarded.
- An all-zero seed loaded in HUNT yields a predicted all-zero stream. It locks only if the input is truly zero; this is acceptable.
- popcount and the counter increment are purely combinational within one cycle; there is no pipelining in this revision.

Decomposition:
- Shared package zl_prbs_pkg:
  - sync-state encodings HUNT/VERIFY/LOCKED
  - function lfsr_step (serial step)
  - function popcount
- One sub-module, zl_prbs_predict: combinational P-step expansion returning {next_state, predicted vector}. Candidate for reuse by the generator.
- Saturating counters stay inline.

Test Plan:
1. Clean stream: W=15, LFSR_poly=16'hC001, P=8, generator init 15'h00A9, 200 beats back-to-back. Expected: HUNT 2 beats, VERIFY 4, locked=1 after the 6th beat edge; err_cnt=0; bit_cnt=1552.
2. Single error: locked, flip in_data[3] on one beat. Expected: err_cnt=1, beat_err pulses once, locked stays 1, following beats error-free (no propagation).
3. Loss of lock: locked, ERR_THRESH=0, feed 4 beats of 8'hFF against prediction. Expected: locked drops on the 4th beat edge, sync_state=0, counters hold; then relocks 6 beats after the clean stream resumes.
4. Gapped valid: same stream as scenario 1 with in_valid toggling 1010… Expected: identical lock beat index and counts as scenario 1.
5. Clear mid-run: clear asserted together with in_valid while locked. Expected: next cycle sync_state=0, err_cnt=bit_cnt=0, beat discarded.
6. Reset and saturation: async rst_n asserted mid-beat, all outputs 0 immediately. With CNT_width=4 and sustained errors, err_cnt sticks at 4'hF.
